dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store sequencer between the execute stage and the byte-lane data memory. It accepts one load or store request at a time and converts it into byte-enabled memory accesses. Misaligned accesses that straddle a word boundary are split into two accesses. Load data is extracted, aligned and zero/sign-extended before being returned to the pipeline. Memory is big-endian: the byte at offset 0 of a word is the most-significant byte.

## Interface
- DATA_WIDTH, 32, request/response data width and memory word width.
- DMEM_DEPTH, 14, number of byte-address bits decoded by data memory.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  DMEM_DEPTH  byte address.
- req_wdata  in  DATA_WIDTH  store value, right-justified.
- rsp_valid  out  1  one-cycle completion pulse for both loads and stores.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- dmem_we  out  4  per-lane write enable; lane k is byte offset k.
- dmem_addr  out  DMEM_DEPTH  byte address; low 2 bits always 00.
- dmem_wdata  out  DATA_WIDTH  lane k is on bits [8k+7:8k].
- dmem_rdata  in  DATA_WIDTH  read word, valid the cycle after the address. Byte offset 0 is on [31:24] and offset 3 on [7:0].

## Operation
- **States:** IDLE, ACC1, ACC2, RESP.
- **Accept:** when req_valid && req_ready, all request fields are registered, and the state goes IDLE→ACC1.
- **Address split:**
  - n = 1, 2 or 4 bytes; o = addr[1:0]; W = addr[DMEM_DEPTH-1:2].
  - Split when o+n > 4.
  - First access: word W, bytes o..min(o+n,4)-1.
  - Second access: word W+1 modulo 2^(DMEM_DEPTH-2), bytes 0..o+n-5. The last word therefore wraps to word 0.
- **Value bytes:** b0 is the most-significant byte of the n-byte value; b_i belongs at address A+i.
- **Stores:**
  - In each access cycle, dmem_we holds exactly the lanes covered by that access.
  - b_i is placed on the lane for (o+i) mod 4.
  - Lanes with we=0 carry 0.
- **Loads:**
  - dmem_we = 0000 at all times.
  - The bytes covered by each access are collected into a holding register from the read word that arrives one cycle later.
  - The assembled value is extended to DATA_WIDTH per req_signed.
- **Transitions:**
  - ACC1→ACC2 if split, otherwise ACC1→RESP.
  - ACC2→RESP.
  - RESP→IDLE, with rsp_valid=1 for that one cycle.
- **No response backpressure.** The consumer must take rsp_* in the RESP cycle.
- **Outside ACC1/ACC2:** dmem_we=0 and dmem_addr=0.

## Timing
- **Reset values:**
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - The holding register is cleared.
- **Accept cycle N:**
  - Unsplit access: memory access at N+1, rsp_valid at N+2.
  - Split access: accesses at N+1 and N+2, rsp_valid at N+3.
- **Load data capture:** read data for the access at cycle C is sampled at C+1.
  - In the split case, first-part data is sampled in ACC2 while the second address is being driven.
- **Issue rate:** req_ready returns to 1 in the cycle after RESP. Minimum issue interval is 3 cycles unsplit and 4 cycles split.
- **Reset mid-operation:** asserting rst_n low in any state immediately forces the reset values. No further writes occur and no rsp_valid is produced for the aborted request.
- **req_valid while not ready:** ignored, not queued.

## Test plan
- **Aligned word:** store 0x12345678 at 0x100 → ACC1 drives dmem_addr=0x100, we=1111, wdata=0x78563412. Then load word 0x100 → rsp_rdata=0x12345678 at N+2.
- **Byte extension:** store byte 0x80 at 0x205 → we=0010, wdata=0x00008000. Signed byte load of 0x205 → 0xFFFFFF80; unsigned → 0x00000080.
- **Split word:** store 0xAABBCCDD at 0x103 → first access addr 0x100, we=1000, lane3=0xAA; second access addr 0x104, we=0111, lanes 0..2 = BB, CC, DD; rsp_valid at N+3. Word load of 0x103 → 0xAABBCCDD.
- **Split half with wrap:** signed half load at 2^DMEM_DEPTH−1, with last byte 0xF0 and byte 0 = 0x01 → second access at dmem_addr=0; rsp_rdata=0xFFFFF001.
- **Reset mid-split:** pull rst_n low during ACC2 of a split store → the second-word lanes stay unwritten, rsp_valid never pulses, and req_ready=1 after release.
- **Back-to-back handshake:** hold req_valid high with 3 queued requests → each is accepted only in IDLE, at 3-cycle spacing; rsp_valid pulses exactly once per request.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store sequencer for a big-endian, byte-lane data memory.
// Word-straddling accesses are issued as two consecutive word accesses.
module dmem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int DMEM_DEPTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DMEM_DEPTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [3:0]            dmem_we,
    output logic [DMEM_DEPTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  store_q;
    logic                  signed_q;
    logic [1:0]            size_q;
    logic [DMEM_DEPTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0][7:0]       hold_q, hold_d;

    logic                  accept;
    logic [1:0]            offs;
    logic [DMEM_DEPTH-3:0] word;
    logic [DMEM_DEPTH-3:0] word_nxt;
    logic [7:0]            size_m;
    logic [7:0]            span;
    logic                  split;
    logic [3:0]            lanes;
    logic [3:0][7:0]       vb;
    logic [3:0][7:0]       rb;
    logic [3:0][7:0]       wl;
    logic [3:0][7:0]       asm_b;
    logic [3:0]            in_first;
    logic [DATA_WIDTH-1:0] load_val;

    assign accept    = req_valid && req_ready;
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);

    assign offs     = addr_q[1:0];
    assign word     = addr_q[DMEM_DEPTH-1:2];
    assign word_nxt = word + (DMEM_DEPTH-2)'(1);

    always_comb begin
        size_m = 8'b0000_1111;
        unique case (size_q)
            2'b00:   size_m = 8'b0000_0001;
            2'b01:   size_m = 8'b0000_0011;
            default: size_m = 8'b0000_1111;
        endcase
    end

    // Bytes touched across the two adjacent words; upper nibble is word W+1.
    assign span  = size_m << offs;
    assign split = |span[7:4];

    // vb[i] is the value byte destined for address A+i.
    always_comb begin
        vb = '0;
        unique case (size_q)
            2'b00: begin
                vb[0] = wdata_q[7:0];
            end
            2'b01: begin
                vb[0] = wdata_q[15:8];
                vb[1] = wdata_q[7:0];
            end
            default: begin
                vb[0] = wdata_q[31:24];
                vb[1] = wdata_q[23:16];
                vb[2] = wdata_q[15:8];
                vb[3] = wdata_q[7:0];
            end
        endcase
    end

    // rb[k] is the read byte at word offset k (offset 0 is the MSB).
    assign rb = {dmem_rdata[7:0], dmem_rdata[15:8],
                 dmem_rdata[23:16], dmem_rdata[31:24]};

    always_comb begin
        lanes     = 4'b0000;
        dmem_addr = '0;
        unique case (state_q)
            S_ACC1: begin
                lanes     = span[3:0];
                dmem_addr = {word, 2'b00};
            end
            S_ACC2: begin
                lanes     = span[7:4];
                dmem_addr = {word_nxt, 2'b00};
            end
            default: begin
                lanes     = 4'b0000;
                dmem_addr = '0;
            end
        endcase
    end

    assign dmem_we = store_q ? lanes : 4'b0000;

    always_comb begin
        wl = '0;
        for (int l = 0; l < 4; l++) begin
            if (dmem_we[l]) begin
                wl[l] = vb[2'(l) - offs];
            end
        end
    end

    assign dmem_wdata = wl;

    always_comb begin
        hold_d = hold_q;
        if (state_q == S_ACC2 && !store_q) begin
            for (int i = 0; i < 4; i++) begin
                hold_d[i] = rb[offs + 2'(i)];
            end
        end
    end

    // Value byte i sits at offset (o+i) mod 4 of whichever word holds it.
    always_comb begin
        in_first = '0;
        asm_b    = '0;
        for (int i = 0; i < 4; i++) begin
            in_first[i] = (({1'b0, offs} + 3'(i)) < 3'd4);
            if (split && in_first[i]) begin
                asm_b[i] = hold_q[i];
            end else begin
                asm_b[i] = rb[offs + 2'(i)];
            end
        end
    end

    always_comb begin
        load_val = '0;
        unique case (size_q)
            2'b00: begin
                load_val = {{(DATA_WIDTH-8){signed_q & asm_b[0][7]}},
                            asm_b[0]};
            end
            2'b01: begin
                load_val = {{(DATA_WIDTH-16){signed_q & asm_b[0][7]}},
                            asm_b[0], asm_b[1]};
            end
            default: begin
                load_val = {asm_b[0], asm_b[1], asm_b[2], asm_b[3]};
            end
        endcase
    end

    assign rsp_rdata = (rsp_valid && !store_q) ? load_val : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = accept ? S_ACC1 : S_IDLE;
            S_ACC1:  state_d = split ? S_ACC2 : S_RESP;
            S_ACC2:  state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            store_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (accept) begin
                store_q  <= req_store;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: random loads/stores against a byte-array model,
// plus directed split, wrap, reset-abort and back-to-back cases.
module tb_dmem_lsu;

    localparam int DW  = 32;
    localparam int AW  = 14;
    localparam int MSZ = 1 << AW;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          req_valid  = 1'b0;
    logic          req_store  = 1'b0;
    logic          req_signed = 1'b0;
    logic [1:0]    req_size   = '0;
    logic [AW-1:0] req_addr   = '0;
    logic [DW-1:0] req_wdata  = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [3:0]    dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata = '0;

    logic [7:0] mem  [MSZ];
    logic [7:0] refm [MSZ];

    int n_chk   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int rsp_cnt = 0;

    dmem_lsu #(.DATA_WIDTH(DW), .DMEM_DEPTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, byte-lane write, offset 0 on the MSB.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        dmem_rdata <= {mem[dmem_addr], mem[dmem_addr | AW'(1)],
                       mem[dmem_addr | AW'(2)], mem[dmem_addr | AW'(3)]};
        for (int k = 0; k < 4; k++) begin
            if (dmem_we[k]) mem[dmem_addr + AW'(k)] = dmem_wdata[8*k +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [AW-1:0] a,
                                             input logic [1:0] sz,
                                             input logic sg);
        int n;
        longint v;
        logic [AW-1:0] ai;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) begin
            ai = a + AW'(i);
            v  = (v << 8) | longint'(refm[ai]);
        end
        if (sg && n < 4 && v >= (longint'(1) << (8*n-1)))
            v = v - (longint'(1) << (8*n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [AW-1:0] a, input logic [1:0] sz,
                             input logic [31:0] wd);
        int n;
        logic [AW-1:0] ai;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) begin
            ai       = a + AW'(i);
            refm[ai] = 8'(wd >> (8*(n-1-i)));
        end
    endtask

    task automatic drive_junk(input logic en);
        req_valid = en;
        if (en) begin
            req_store  = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = AW'($urandom);
            req_wdata  = $urandom;
        end
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz,
                          input logic sg, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic junk,
                          output logic [31:0] got_r,
                          output logic [3:0] got_we,
                          output logic [31:0] got_wd);
        int n;
        logic [AW-3:0] w1, w2;
        logic [AW-1:0] ai;
        logic [3:0]    we1, we2;
        logic [31:0]   wd1, wd2, exp_r;
        logic [7:0]    bi;
        logic          split;
        n  = nbytes(sz);
        w1 = a[AW-1:2];
        w2 = w1 + (AW-2)'(1);
        we1 = '0; we2 = '0; wd1 = '0; wd2 = '0; split = 1'b0;
        for (int i = 0; i < n; i++) begin
            ai = a + AW'(i);
            bi = 8'(wd >> (8*(n-1-i)));
            if (ai[AW-1:2] == w1) begin
                we1[ai[1:0]] = 1'b1;
                wd1[8*ai[1:0] +: 8] = bi;
            end else begin
                split = 1'b1;
                we2[ai[1:0]] = 1'b1;
                wd2[8*ai[1:0] +: 8] = bi;
            end
        end
        if (!st) begin
            we1 = '0; we2 = '0; wd1 = '0; wd2 = '0;
        end
        exp_r = st ? 32'h0 : ref_load(a, sz, sg);

        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_rsp", 32'(rsp_valid), 32'd0);
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;

        @(negedge clk);
        drive_junk(junk);
        check("acc1_ready", 32'(req_ready), 32'd0);
        check("acc1_addr", 32'(dmem_addr), 32'({w1, 2'b00}));
        check("acc1_we", 32'(dmem_we), 32'(we1));
        check("acc1_wdata", dmem_wdata, wd1);
        got_we = dmem_we;
        got_wd = dmem_wdata;

        if (split) begin
            @(negedge clk);
            drive_junk(junk);
            check("acc2_rsp", 32'(rsp_valid), 32'd0);
            check("acc2_addr", 32'(dmem_addr), 32'({w2, 2'b00}));
            check("acc2_we", 32'(dmem_we), 32'(we2));
            check("acc2_wdata", dmem_wdata, wd2);
        end

        @(negedge clk);
        req_valid = 1'b0;
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_rdata", rsp_rdata, exp_r);
        check("resp_we", 32'(dmem_we), 32'd0);
        check("resp_addr", 32'(dmem_addr), 32'd0);
        got_r = rsp_rdata;
        if (st) ref_store(a, sz, wd);
    endtask

    logic          b_st [3];
    logic [1:0]    b_sz [3];
    logic          b_sg [3];
    logic [AW-1:0] b_ad [3];
    logic [31:0]   b_wd [3];

    task automatic set_req(input int k);
        req_valid  = 1'b1;
        req_store  = b_st[k];
        req_size   = b_sz[k];
        req_signed = b_sg[k];
        req_addr   = b_ad[k];
        req_wdata  = b_wd[k];
    endtask

    initial begin
        logic [31:0]   g_r, g_wd;
        logic [3:0]    g_we;
        logic [7:0]    b;
        logic [AW-1:0] ra;
        logic          acc;
        int            base, k, nr, r;
        int            acc_cyc [3];
        logic [31:0]   expq [$];

        for (int i = 0; i < MSZ; i++) begin
            b = 8'($urandom);
            mem[i]  = b;
            refm[i] = b;
        end

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", 32'(dmem_addr), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        rst_n = 1'b1;

        do_req(1'b1, 2'b10, 1'b0, 14'h100, 32'h12345678, 1'b0, g_r, g_we, g_wd);
        check("word_st_we", 32'(g_we), 32'hF);
        check("word_st_wdata", g_wd, 32'h78563412);
        do_req(1'b0, 2'b10, 1'b0, 14'h100, 32'h0, 1'b0, g_r, g_we, g_wd);
        check("word_ld", g_r, 32'h12345678);

        do_req(1'b1, 2'b00, 1'b0, 14'h205, 32'h80, 1'b0, g_r, g_we, g_wd);
        check("byte_st_we", 32'(g_we), 32'h2);
        check("byte_st_wdata", g_wd, 32'h00008000);
        do_req(1'b0, 2'b00, 1'b1, 14'h205, 32'h0, 1'b0, g_r, g_we, g_wd);
        check("byte_ld_s", g_r, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b0, 14'h205, 32'h0, 1'b0, g_r, g_we, g_wd);
        check("byte_ld_u", g_r, 32'h00000080);

        do_req(1'b1, 2'b10, 1'b0, 14'h103, 32'hAABBCCDD, 1'b0, g_r, g_we, g_wd);
        check("split_st_we1", 32'(g_we), 32'h8);
        check("split_st_wd1", g_wd, 32'hAA000000);
        do_req(1'b0, 2'b10, 1'b0, 14'h103, 32'h0, 1'b0, g_r, g_we, g_wd);
        check("split_ld", g_r, 32'hAABBCCDD);

        do_req(1'b1, 2'b00, 1'b0, 14'h3FFF, 32'hF0, 1'b0, g_r, g_we, g_wd);
        do_req(1'b1, 2'b00, 1'b0, 14'h0000, 32'h01, 1'b0, g_r, g_we, g_wd);
        do_req(1'b0, 2'b01, 1'b1, 14'h3FFF, 32'h0, 1'b0, g_r, g_we, g_wd);
        check("wrap_half", g_r, 32'hFFFFF001);

        // Abort a split store during its second access.
        @(negedge clk);
        base       = rsp_cnt;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 14'h207;
        req_wdata  = 32'hCAFEBABE;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_acc1_we", 32'(dmem_we), 32'h8);
        @(negedge clk);
        check("abort_acc2_we", 32'(dmem_we), 32'h7);
        rst_n = 1'b0;
        #1;
        check("abort_we", 32'(dmem_we), 32'd0);
        check("abort_addr", 32'(dmem_addr), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rsp", 32'(rsp_valid), 32'd0);
        refm[14'h207] = 8'hCA;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_cnt - base), 32'd0);
        check("abort_ready_after", 32'(req_ready), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 14'h208, 32'h0, 1'b0, g_r, g_we, g_wd);
        do_req(1'b0, 2'b00, 1'b0, 14'h207, 32'h0, 1'b0, g_r, g_we, g_wd);
        check("abort_first_byte", g_r, 32'h000000CA);

        // Three requests queued behind a permanently high req_valid.
        b_st[0] = 1'b1; b_sz[0] = 2'b10; b_sg[0] = 1'b0;
        b_ad[0] = 14'h120; b_wd[0] = 32'h8899AABB;
        b_st[1] = 1'b0; b_sz[1] = 2'b10; b_sg[1] = 1'b0;
        b_ad[1] = 14'h120; b_wd[1] = 32'h0;
        b_st[2] = 1'b0; b_sz[2] = 2'b01; b_sg[2] = 1'b1;
        b_ad[2] = 14'h122; b_wd[2] = 32'h0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
        @(negedge clk);
        base = rsp_cnt;
        k    = 0;
        nr   = 0;
        set_req(0);
        for (int c = 0; c < 40 && nr < 3; c++) begin
            if (rsp_valid) begin
                if (expq.size() == 0) begin
                    check("b2b_extra_rsp", 32'd1, 32'd0);
                end else begin
                    check("b2b_rdata", rsp_rdata, expq.pop_front());
                end
                nr++;
            end
            acc = req_valid && req_ready;
            if (acc) begin
                acc_cyc[k] = cyc;
                if (b_st[k]) begin
                    expq.push_back(32'h0);
                    ref_store(b_ad[k], b_sz[k], b_wd[k]);
                end else begin
                    expq.push_back(ref_load(b_ad[k], b_sz[k], b_sg[k]));
                end
                k++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (k < 3) set_req(k);
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", 32'(k), 32'd3);
        check("b2b_rsps", 32'(nr), 32'd3);
        check("b2b_pulses", 32'(rsp_cnt - base), 32'd3);
        check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 3);
            if (r < 2) ra = 14'h100 + AW'($urandom_range(0, 63));
            else if (r == 2) ra = 14'h3FF0 + AW'($urandom_range(0, 15));
            else ra = AW'($urandom);
            do_req(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom,
                   1'($urandom), g_r, g_we, g_wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
